// File: rtl/mark_available_allocator.sv
// mark_available_allocator: chunked scan for the lowest free cell, reserving it and returning its handle
module mark_available_allocator #(
  parameter int NUM_CELLS  = 16,
  parameter int SCAN_WIDTH = 4,
  parameter int HANDLE_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CELLS-1:0] elt_def,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_found,
  output logic [HANDLE_W-1:0]  resp_handle,
  input  logic                 release_valid,
  input  logic [HANDLE_W-1:0]  release_handle,
  output logic [NUM_CELLS-1:0] reserved
);
  localparam int PW = HANDLE_W + 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_CELLS - SCAN_WIDTH);
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, hit_off, hit_idx;
  logic [SCAN_WIDTH-1:0] chunk_free;
  logic [NUM_CELLS-1:0] set_mask, rel_mask, reserved_n;
  logic [HANDLE_W-1:0] handle_n;
  logic hit, found_n, resp_valid_n;
  assign req_ready = state == IDLE;
  assign chunk_free = SCAN_WIDTH'(~((elt_def | reserved) >> ptr));
  assign hit_idx = ptr + hit_off;
  assign rel_mask = release_valid ? NUM_CELLS'(1) << release_handle : '0;
  assign reserved_n = (reserved & ~elt_def & ~rel_mask) | set_mask;
  assign resp_valid_n = state == RESP && !(resp_valid && resp_ready);
  always_comb begin
    hit = 1'b0;
    hit_off = '0;
    for (int j = SCAN_WIDTH - 1; j >= 0; j--)
      if (chunk_free[j]) begin
        hit = 1'b1;
        hit_off = PW'(j);
      end
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    found_n = resp_found;
    handle_n = resp_handle;
    set_mask = '0;
    if (state == IDLE && req_valid) begin
      state_n = SCAN;
      ptr_n = '0;
    end
    if (state == SCAN) begin
      if (hit) begin
        state_n = RESP;
        found_n = 1'b1;
        handle_n = HANDLE_W'(hit_idx);
        set_mask = NUM_CELLS'(1) << hit_idx;
      end else if (ptr == LAST) begin
        state_n = RESP;
        found_n = 1'b0;
        handle_n = '0;
      end else
        ptr_n = ptr + PW'(SCAN_WIDTH);
    end
    if (state == RESP && resp_valid && resp_ready) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      reserved <= '0;
      resp_valid <= 1'b0;
      resp_found <= 1'b0;
      resp_handle <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      reserved <= reserved_n;
      resp_valid <= resp_valid_n;
      resp_found <= found_n;
      resp_handle <= handle_n;
    end
  end
endmodule

// File: tb/tb_mark_available_allocator.sv
// tb_mark_available_allocator: randomized scoreboard bench for mark_available_allocator
module tb_mark_available_allocator;
  localparam int N = 16;
  localparam int SW = 4;
  typedef struct {bit found; logic [7:0] handle; int lat; int acc;} exp_t;
  logic clk = 0;
  logic reset, req_valid, req_ready, resp_valid, resp_ready, resp_found, release_valid;
  logic [N-1:0] elt_def, reserved, mres;
  logic [7:0] resp_handle, release_handle;
  int total = 0, bad = 0, cyc = 0, nresp = 0;
  exp_t q[$];
  bit mon_pend = 0, held_f;
  logic [7:0] held_h;
  mark_available_allocator #(.NUM_CELLS(N), .SCAN_WIDTH(SW), .HANDLE_W(8)) dut (
    .clk(clk), .reset(reset), .elt_def(elt_def), .req_valid(req_valid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
    .resp_handle(resp_handle), .release_valid(release_valid), .release_handle(release_handle),
    .reserved(reserved)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  function automatic exp_t model_alloc(int acc);
    exp_t e;
    e.found = 0;
    e.handle = 0;
    e.lat = N / SW + 1;
    e.acc = acc;
    for (int i = N - 1; i >= 0; i--)
      if (!elt_def[i] && !mres[i]) begin
        e.found = 1;
        e.handle = 8'(i);
        e.lat = i / SW + 2;
      end
    return e;
  endfunction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reset) mon_pend = 0;
      else if (resp_valid) begin
        chk("req_ready_in_resp", req_ready, 0);
        if (!mon_pend) begin
          nresp++;
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: got handle %0d want no response", resp_handle);
          end else begin
            e = q.pop_front();
            chk("resp_found", resp_found, e.found);
            chk("resp_handle", resp_handle, e.handle);
            chk("resp_latency", cyc - e.acc, e.lat);
            held_f = resp_found;
            held_h = resp_handle;
          end
        end else begin
          chk("hold_found", resp_found, held_f);
          chk("hold_handle", resp_handle, held_h);
        end
        mon_pend = !resp_ready;
      end else mon_pend = 0;
    end
  end
  task automatic do_req(int hold);
    exp_t e;
    int n;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    chk("req_ready_idle", req_ready, 1);
    e = model_alloc(cyc + 1);
    q.push_back(e);
    req_valid = 1;
    resp_ready = hold == 0;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      chk("resp_timeout", resp_valid, 1);
      q.delete();
      resp_ready = 1;
      return;
    end
    for (int k = 0; k < hold; k++) begin
      if (k == 1) req_valid = 1;
      @(negedge clk);
      req_valid = 0;
    end
    resp_ready = 1;
    @(negedge clk);
    if (e.found) mres = mres | (N'(1) << e.handle);
    chk("reserved_after_resp", reserved, mres);
  endtask
  task automatic set_elt(logic [N-1:0] v);
    elt_def = v;
    @(negedge clk);
    mres = mres & ~v;
    chk("reserved_after_elt", reserved, mres);
  endtask
  task automatic do_release(logic [7:0] h);
    release_valid = 1;
    release_handle = h;
    @(negedge clk);
    release_valid = 0;
    mres = mres & ~(N'(1) << h);
    chk("reserved_after_release", reserved, mres);
  endtask
  initial begin
    int saved, r;
    reset = 1;
    req_valid = 0;
    resp_ready = 1;
    elt_def = 0;
    release_valid = 0;
    release_handle = 0;
    mres = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_found", resp_found, 0);
    chk("rst_resp_handle", resp_handle, 0);
    chk("rst_reserved", reserved, 0);
    reset = 0;
    @(negedge clk);
    do_req(0);
    chk("empty_reserved", reserved, 16'h0001);
    set_elt(16'h03FF);
    do_req(0);
    do_req(0);
    chk("b2b_reserved", reserved, 16'h0C00);
    set_elt(16'hFFFF);
    do_req(0);
    chk("full_reserved", reserved, 16'h0000);
    set_elt(16'h001F);
    do_req(0);
    chk("life_res5", reserved, 16'h0020);
    set_elt(16'h003F);
    chk("life_clr5", reserved, 16'h0000);
    do_req(0);
    do_release(8'd6);
    chk("life_rel6", reserved, 16'h0000);
    do_req(0);
    chk("life_realloc6", reserved, 16'h0040);
    do_release(8'd200);
    do_release(8'd3);
    chk("rel_ignored", reserved, 16'h0040);
    do_req(3);
    set_elt(16'hFFFF);
    set_elt(16'h0000);
    do_req(0);
    do_req(0);
    chk("pre_reset_reserved", reserved, 16'h0003);
    saved = nresp;
    elt_def = 16'h0FFF;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    reset = 1;
    @(negedge clk);
    chk("midscan_req_ready", req_ready, 1);
    chk("midscan_reserved", reserved, 0);
    chk("midscan_resp_valid", resp_valid, 0);
    reset = 0;
    mres = 0;
    repeat (10) @(negedge clk);
    chk("midscan_no_resp", nresp, saved);
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r < 2) set_elt((r == 0 && $urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom & $urandom));
      else if (r < 4) do_release(($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 17)));
      else do_req($urandom_range(0, 3));
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
